// File: rtl/rram_pkg.sv
// rtl/rram_pkg.sv - shared op encodings, state enum and helpers for the RRAM crossbar sequencer
package rram_pkg;

    localparam int RRAM_N     = 2;
    localparam int RRAM_ROW_W = (RRAM_N > 1) ? $clog2(RRAM_N) : 1;

    localparam logic RRAM_OP_PROG    = 1'b0;
    localparam logic RRAM_OP_COMPUTE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_PULSE   = 2'd2,
        ST_RECOVER = 2'd3
    } rram_state_e;

    function automatic int rram_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [RRAM_N-1:0] rram_onehot(input logic [RRAM_ROW_W-1:0] row);
        logic [RRAM_N-1:0] one;
        one = {{(RRAM_N-1){1'b0}}, 1'b1};
        return one << row;
    endfunction

endpackage

// File: rtl/rram_xbar_seq_if.sv
// rtl/rram_xbar_seq_if.sv - command/response handshake bundle between scheduler and sequencer
interface rram_xbar_seq_if
    import rram_pkg::*;
;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [RRAM_ROW_W-1:0] cmd_row;
    logic [RRAM_N-1:0]     cmd_data;
    logic                  rsp_valid;
    logic [RRAM_N-1:0]     rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/rram_phase_timer.sv
// rtl/rram_phase_timer.sv - loadable down-counter that parks at zero and flags it
module rram_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rram_xbar_seq.sv
// rtl/rram_xbar_seq.sv - setup/pulse/recover sequencer driving the 2x2 RRAM crossbar controls
module rram_xbar_seq
    import rram_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int SETTLE_CYC  = 3,
    parameter int RECOVER_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    rram_xbar_seq_if.slave    bus,
    output logic [RRAM_N-1:0] Dwl,
    output logic [RRAM_N-1:0] Dsl,
    output logic [RRAM_N-1:0] Dbl,
    output logic              Dset,
    input  logic [RRAM_N-1:0] sum_cmp,
    output logic              busy
);

    localparam int CW = $clog2(rram_max4(SETUP_CYC, PULSE_CYC, SETTLE_CYC, RECOVER_CYC)) + 1;

    rram_state_e           state_q, state_n;
    logic                  op_q, op_n;
    logic [RRAM_ROW_W-1:0] row_q, row_n;
    logic [RRAM_N-1:0]     data_q, data_n;
    logic                  accept;
    logic                  tmr_load;
    logic [CW-1:0]         tmr_val;
    logic [CW-1:0]         cnt;
    logic                  cnt_zero;
    logic                  rsp_hit;
    logic [RRAM_N-1:0]     dwl_d, dbl_d;
    logic                  dset_d;

    rram_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;
    assign op_n   = accept ? bus.cmd_op   : op_q;
    assign row_n  = accept ? bus.cmd_row  : row_q;
    assign data_n = accept ? bus.cmd_data : data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= RRAM_OP_PROG;
            row_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            row_q   <= row_n;
            data_q  <= data_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) begin
                state_n  = ST_SETUP;
                tmr_load = 1'b1;
                tmr_val  = CW'(SETUP_CYC - 1);
            end
            ST_SETUP: if (cnt_zero) begin
                state_n  = ST_PULSE;
                tmr_load = 1'b1;
                tmr_val  = CW'(PULSE_CYC - 1);
            end
            ST_PULSE: if (cnt_zero) begin
                state_n  = ST_RECOVER;
                tmr_load = 1'b1;
                tmr_val  = CW'(RECOVER_CYC - 1);
            end
            ST_RECOVER: if (cnt_zero) begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered controls line up with the phase.
    always_comb begin
        dwl_d  = '0;
        dset_d = 1'b0;
        dbl_d  = '0;
        if (state_n != ST_IDLE) begin
            if (op_n == RRAM_OP_PROG) begin
                dwl_d  = rram_onehot(row_n);
                dset_d = 1'b1;
            end else begin
                dwl_d = '1;
            end
            if (state_n == ST_PULSE) begin
                dbl_d = data_n;
            end
        end
    end

    // Pulse index k carries cnt == PULSE_CYC-1-k, so the sample point is cnt == PULSE_CYC-SETTLE_CYC.
    assign rsp_hit = (state_q == ST_PULSE) && (op_q == RRAM_OP_COMPUTE)
                     && (cnt == CW'(PULSE_CYC - SETTLE_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Dwl           <= '0;
            Dsl           <= '0;
            Dbl           <= '0;
            Dset          <= 1'b0;
            busy          <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            Dwl           <= dwl_d;
            Dsl           <= '0;
            Dbl           <= dbl_d;
            Dset          <= dset_d;
            busy          <= (state_n != ST_IDLE);
            bus.cmd_ready <= (state_n == ST_IDLE);
            bus.rsp_valid <= rsp_hit;
            if (rsp_hit) begin
                bus.rsp_data <= sum_cmp;
            end
        end
    end

endmodule

// File: tb/tb_rram_xbar_seq.sv
// tb/tb_rram_xbar_seq.sv - directed self-checking bench for the RRAM crossbar sequencer
module tb_rram_xbar_seq;
    import rram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rram_xbar_seq_if bus_a ();
    rram_xbar_seq_if bus_b ();

    logic [1:0] dwl_a, dsl_a, dbl_a, sum_a;
    logic       dset_a, busy_a;
    logic [1:0] dwl_b, dsl_b, dbl_b, sum_b;
    logic       dset_b, busy_b;

    rram_xbar_seq dut_a (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_a),
        .Dwl     (dwl_a),
        .Dsl     (dsl_a),
        .Dbl     (dbl_a),
        .Dset    (dset_a),
        .sum_cmp (sum_a),
        .busy    (busy_a)
    );

    rram_xbar_seq #(
        .SETUP_CYC   (1),
        .PULSE_CYC   (1),
        .SETTLE_CYC  (1),
        .RECOVER_CYC (1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_b),
        .Dwl     (dwl_b),
        .Dsl     (dsl_b),
        .Dbl     (dbl_b),
        .Dset    (dset_b),
        .sum_cmp (sum_b),
        .busy    (busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ready, busy, Dwl, Dset, Dbl, rsp_valid, Dsl}
    function automatic logic [9:0] vec_a();
        return {bus_a.cmd_ready, busy_a, dwl_a, dset_a, dbl_a, bus_a.rsp_valid, dsl_a};
    endfunction

    function automatic logic [9:0] vec_b();
        return {bus_b.cmd_ready, busy_b, dwl_b, dset_b, dbl_b, bus_b.rsp_valid, dsl_b};
    endfunction

    logic [1:0] prev_dbl = 2'b00;
    logic       prev_dset = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_dbl != 2'b00 && dbl_a != 2'b00) chk("dset_stable", dset_a, prev_dset);
            if (dbl_a != 2'b00) chk("dbl_needs_wl", dwl_a != 2'b00, 1'b1);
        end
        prev_dbl  <= dbl_a;
        prev_dset <= dset_a;
    end

    // Default timing: SETUP 2, PULSE 4, SETTLE 3, RECOVER 2; k counts cycles after the accept edge.
    task automatic run_cmd(input string tag, input logic op, input logic row, input logic [1:0] data,
                           input bit tog, input logic [1:0] exp_rsp);
        logic [1:0] wl;
        logic [9:0] e;
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_op    = op;
        bus_a.cmd_row   = row;
        bus_a.cmd_data  = data;
        wl = op ? 2'b11 : (row ? 2'b10 : 2'b01);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus_a.cmd_valid = 1'b0;
            e = {k == 9, k <= 8, (k <= 8) ? wl : 2'b00, (k <= 8) && !op,
                 (k >= 3 && k <= 6) ? data : 2'b00, op && (k == 6), 2'b00};
            chk({tag, "_vec"}, vec_a(), e);
            if (op && k == 6) chk({tag, "_rsp_data"}, bus_a.rsp_data, exp_rsp);
            if (tog) sum_a = k[0] ? 2'b10 : 2'b01;
        end
    endtask

    logic       ops   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       rows  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] datas [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    int         rsp_cnt;

    initial begin
        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 1'b0; bus_a.cmd_row = 1'b0; bus_a.cmd_data = 2'b00;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = 1'b0; bus_b.cmd_row = 1'b0; bus_b.cmd_data = 2'b00;
        sum_a = 2'b00;
        sum_b = 2'b00;

        @(negedge clk);
        chk("reset_a", vec_a(), 10'b10_00_0_00_0_00);
        chk("reset_b", vec_b(), 10'b10_00_0_00_0_00);
        chk("reset_rsp_data", bus_a.rsp_data, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a PROG pulse.
        bus_a.cmd_valid = 1'b1; bus_a.cmd_op = 1'b0; bus_a.cmd_row = 1'b1; bus_a.cmd_data = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus_a.cmd_valid = 1'b0;
        end
        chk("abort_pre_pulse", vec_a(), 10'b01_10_1_11_0_00);
        rst = 1'b1;
        #1;
        chk("abort_async", vec_a(), 10'b10_00_0_00_0_00);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_quiet", vec_a(), 10'b10_00_0_00_0_00);
        end

        run_cmd("prog_r0_d10", 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
        run_cmd("prog_r1_d00", 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        sum_a = 2'b01;
        run_cmd("comp_d11", 1'b1, 1'b0, 2'b11, 1'b0, 2'b01);
        sum_a = 2'b01;
        run_cmd("comp_toggle", 1'b1, 1'b0, 2'b01, 1'b1, 2'b10);

        // cmd_valid held high; the next command is presented right after each accept.
        sum_a = 2'b11;
        rsp_cnt = 0;
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_op = ops[0]; bus_a.cmd_row = rows[0]; bus_a.cmd_data = datas[0];
        for (int c = 0; c < 36; c++) begin
            int i, ph;
            i  = c / 9;
            ph = c % 9;
            chk("b2b_ready", bus_a.cmd_ready, ph == 0);
            if (ph == 1) chk("b2b_wl", dwl_a, ops[i] ? 2'b11 : (rows[i] ? 2'b10 : 2'b01));
            if (ph == 3) chk("b2b_bl", dbl_a, datas[i]);
            if (bus_a.rsp_valid) rsp_cnt++;
            if (ph == 1 && i < 3) begin
                bus_a.cmd_op = ops[i+1]; bus_a.cmd_row = rows[i+1]; bus_a.cmd_data = datas[i+1];
            end
            @(negedge clk);
        end
        bus_a.cmd_valid = 1'b0;
        chk("b2b_end_ready", bus_a.cmd_ready, 1'b1);
        @(negedge clk);
        chk("b2b_no_extra", vec_a(), 10'b10_00_0_00_0_00);
        chk("b2b_rsp_count", rsp_cnt, 2);

        // Minimum timing: one cycle per phase.
        sum_b = 2'b10;
        bus_b.cmd_valid = 1'b1; bus_b.cmd_op = 1'b1; bus_b.cmd_row = 1'b0; bus_b.cmd_data = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            logic [9:0] e;
            @(negedge clk);
            bus_b.cmd_valid = 1'b0;
            e = {k == 4, k <= 3, (k <= 3) ? 2'b11 : 2'b00, 1'b0, (k == 2) ? 2'b11 : 2'b00, k == 3, 2'b00};
            chk("sweep_vec", vec_b(), e);
            if (k == 3) chk("sweep_rsp_data", bus_b.rsp_data, 2'b10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
